// File: rtl/apb_ucpd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : apb_ucpd_pkg
// Description : Shared constants for the UCPD receive path: flag bit indices,
//               ordered-set encoding (mirrors the UCPD core) and buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_ucpd_pkg;

    // Bit positions of the RX flags inside the interrupt-enable vector
    localparam int RXNE_IDX     = 0;
    localparam int RXOVR_IDX    = 1;
    localparam int RXMSGEND_IDX = 2;
    localparam int RXERR_IDX    = 3;

    // Default receive buffer depth in bytes
    localparam int RX_BUF_DEPTH = 4;

    // Ordered-set codes as reported by the UCPD core
    typedef enum logic [2:0] {
        SOP       = 3'd0,
        SOP1      = 3'd1,
        SOP2      = 3'd2,
        SOP1_DBG  = 3'd3,
        SOP2_DBG  = 3'd4,
        CABLE_RST = 3'd5,
        SOPEXT1   = 3'd6,
        SOPEXT2   = 3'd7
    } ordset_e;

endpackage
`default_nettype wire

// File: rtl/apb_ucpd_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_ucpd_sync_fifo
// Description : Generic single-clock FIFO with count, full/empty, a synchronous
//               flush and a drop indication for pushes that find no room.
//               Head data is combinational and reads zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_ucpd_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0]   c_full_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop_ok;
    logic w_push_ok;

    // A pop on a full FIFO frees the slot the simultaneous push needs
    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage is intentionally not reset; only written on accepted pushes
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_ucpd_rx_buf.sv
`default_nettype none
// ============================================================================
// Module      : apb_ucpd_rx_buf
// Description : UCPD receive byte buffer. Queues decoded bytes for RXDR reads,
//               keeps the sticky RXOVR/RXMSGEND/RXERR flags, latches the
//               payload size and ordered set at end of message and drives the
//               registered RX interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_ucpd_rx_buf
    import apb_ucpd_pkg::*;
#(
    parameter int DEPTH = RX_BUF_DEPTH,
    parameter int AW    = 2
) (
    input  logic          ic_clk,
    input  logic          ic_rst,
    input  logic          ucpden,
    input  logic          rx_byte_vld,
    input  logic [7:0]    rx_data,
    input  logic          rx_msg_end,
    input  logic          rx_crc_ok,
    input  logic [9:0]    rx_paysize,
    input  logic [6:0]    rx_ordset,
    input  logic          rxdr_rd,
    input  logic [2:0]    flag_clr,
    input  logic [3:0]    int_en,
    output logic [7:0]    rxdr,
    output logic          rxne,
    output logic          rxovr,
    output logic          rxmsgend,
    output logic          rxerr,
    output logic [9:0]    rxpaysz,
    output logic [6:0]    rxordset,
    output logic [AW:0]   fifo_lvl,
    output logic          rx_irq
);

    logic       w_empty;
    logic       w_full;
    logic       w_drop;
    logic [3:0] w_flags;

    logic       r_rxovr;
    logic       r_rxmsgend;
    logic       r_rxerr;
    logic [9:0] r_rxpaysz;
    logic [6:0] r_rxordset;
    logic       r_irq;

    // Byte queue; a disabled peripheral flushes it and ignores incoming bytes
    apb_ucpd_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (8)
    ) u_fifo (
        .clk     (ic_clk),
        .rst     (ic_rst),
        .i_flush (~ucpden),
        .i_push  (rx_byte_vld & ucpden),
        .i_wdata (rx_data),
        .i_pop   (rxdr_rd),
        .o_rdata (rxdr),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (fifo_lvl)
    );

    assign rxne     = ~w_empty;
    assign rxovr    = r_rxovr;
    assign rxmsgend = r_rxmsgend;
    assign rxerr    = r_rxerr;
    assign rxpaysz  = r_rxpaysz;
    assign rxordset = r_rxordset;
    assign rx_irq   = r_irq & ucpden;

    // Flag vector in interrupt-enable bit order
    always_comb begin
        w_flags               = '0;
        w_flags[RXNE_IDX]     = rxne;
        w_flags[RXOVR_IDX]    = r_rxovr;
        w_flags[RXMSGEND_IDX] = r_rxmsgend;
        w_flags[RXERR_IDX]    = r_rxerr;
    end

    // Sticky flags (set beats clear), end-of-message latches and IRQ register
    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            r_rxovr    <= 1'b0;
            r_rxmsgend <= 1'b0;
            r_rxerr    <= 1'b0;
            r_rxpaysz  <= '0;
            r_rxordset <= '0;
            r_irq      <= 1'b0;
        end else if (!ucpden) begin
            r_rxovr    <= 1'b0;
            r_rxmsgend <= 1'b0;
            r_rxerr    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_rxovr <= 1'b1;
            end else if (flag_clr[0]) begin
                r_rxovr <= 1'b0;
            end

            if (rx_msg_end) begin
                r_rxmsgend <= 1'b1;
            end else if (flag_clr[1]) begin
                r_rxmsgend <= 1'b0;
            end

            if (rx_msg_end && !rx_crc_ok) begin
                r_rxerr <= 1'b1;
            end else if (flag_clr[2]) begin
                r_rxerr <= 1'b0;
            end

            if (rx_msg_end) begin
                r_rxpaysz  <= rx_paysize;
                r_rxordset <= rx_ordset;
            end

            r_irq <= |(int_en & w_flags);
        end
    end

    // The full flag is only consumed through the drop indication
    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: doc/apb_ucpd_rx_buf.md
Name: apb_ucpd_rx_buf

Overview:
- Receive-side byte buffer sitting directly downstream of the UCPD core and upstream of the APB register file.
- Accepts decoded payload bytes and end-of-message events from the core and buffers bytes in a small FIFO, so the firmware/DMA RXDR read latency is decoupled from line bit timing.
- Maintains the RXNE, RXOVR, RXMSGEND and RXERR flags and latches RXPAYSZ/RXORDSET.
- Drives the RX interrupt request.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- ic_clk  input  1  UCPD kernel clock (HSI16).
- ic_rst  input  1  asynchronous, active-high reset.
- ucpden  input  1  peripheral enable; low = synchronous flush.
- rx_byte_vld  input  1  one-cycle pulse from core; rx_data is valid.
- rx_data  input  8  received byte (CRC already stripped).
- rx_msg_end  input  1  one-cycle pulse: EOP seen, message finished.
- rx_crc_ok  input  1  CRC result, valid with rx_msg_end.
- rx_paysize  input  10  byte count from core, valid with rx_msg_end.
- rx_ordset  input  7  ordered-set code from core, valid with rx_msg_end.
- rxdr_rd  input  1  one-cycle APB read strobe of RXDR.
- flag_clr  input  3  W1C pulses: [0] RXOVR, [1] RXMSGEND, [2] RXERR.
- int_en  input  4  enables: [0] RXNE, [1] RXOVR, [2] RXMSGEND, [3] RXERR.
- rxdr  output  8  FIFO head byte.
- rxne  output  1  FIFO not empty.
- rxovr  output  1  sticky overrun.
- rxmsgend  output  1  sticky message end.
- rxerr  output  1  sticky CRC error at message end.
- rxpaysz  output  10  latched payload size.
- rxordset  output  7  latched ordered set.
- fifo_lvl  output  AW+1  current occupancy.
- rx_irq  output  1  registered OR of enabled flags.

Behaviour:
- Reset: all outputs are 0. Pointers and count are 0. FIFO storage is not reset.
- FIFO structure: wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. count is AW+1 bits. full = (count == DEPTH). empty = (count == 0).
- Push: on rx_byte_vld while not full, write rx_data at wr_ptr, increment wr_ptr, increment count.
- rxdr is combinational from mem[rd_ptr] and is valid in the same cycle rxne is high.
- Push latency: a byte pushed in cycle N appears on rxdr/rxne at cycle N+1.
- Pop: on rxdr_rd while not empty, increment rd_ptr and decrement count. The byte read is the rxdr value in that cycle.
- Read when empty: rxdr reads 0x00 (rxdr is gated to 0 when empty). No pointer change, no flag.
- Push when full: the byte is dropped and rxovr is set on the next edge. Pointers are unchanged.
- Simultaneous push and pop, not empty: both occur, count is unchanged.
  - If full: the pop frees a slot, so the push is accepted and rxovr is not set.
  - If empty: the pop is ignored and the push is accepted.
- Message end: on rx_msg_end, latch rx_paysize into rxpaysz and rx_ordset into rxordset, and set rxmsgend. If rx_crc_ok == 0, also set rxerr.
- Message end with a byte pulse in the same cycle: the byte is pushed first, so it belongs to the ending message.
- Sticky flags are cleared by the matching flag_clr bit.
- Set and clear in the same cycle: set wins.
- rxne is not clearable; it follows FIFO occupancy.
- rx_irq = |(int_en & {rxerr, rxmsgend, rxovr, rxne}), registered (1-cycle latency from the flag).
- ucpden low: pointers and count go to 0, all sticky flags go to 0, and rxpaysz/rxordset hold their values.
  - While ucpden is low, pushes are ignored and rx_irq is 0.
- Async reset mid-message: immediate clear. The partially received message is discarded, with no flag.
- Counter widths:
  - count never exceeds DEPTH.
  - rxpaysz is 10 bits; the core saturates it at 1023 and this block passes it unchanged.

Decomposition:
- Shared package apb_ucpd_pkg holds:
  - Flag bit indices: RXNE_IDX=0, RXOVR_IDX=1, RXMSGEND_IDX=2, RXERR_IDX=3.
  - Ordered-set codes (SOP=0, SOP1=1, SOP2=2, SOP1_DBG=3, SOP2_DBG=4, CABLE_RST=5, SOPEXT1=6, SOPEXT2=7), mirroring the core's encoding.
  - RX_BUF_DEPTH default.
- One sub-module is natural: apb_ucpd_sync_fifo, a generic single-clock FIFO with full/empty/count.
  - This block wraps it with the flag, latch and interrupt logic.

Test Plan:
- Push 0xA1, 0xB2, 0xC3 with no reads -> fifo_lvl=3 and rxdr=0xA1. Three rxdr_rd strobes return A1, B2, C3, then rxne=0 and rxdr=0x00.
- Push 5 bytes 0x01..0x05 into DEPTH=4 with no reads -> fifo_lvl=4, rxovr=1, 0x05 dropped, reads return 01..04. flag_clr[0] -> rxovr=0.
- FIFO full plus simultaneous rxdr_rd and rx_byte_vld(0x77) -> rxovr stays 0, fifo_lvl stays 4, and 0x77 is read last.
- rx_msg_end with paysize=0x01E, ordset=3, crc_ok=0, int_en=4'b1100 -> rxpaysz=0x01E, rxordset=3, rxmsgend=1, rxerr=1. rx_irq=1 one cycle after.
- flag_clr[1] asserted in the same cycle as a new rx_msg_end -> rxmsgend remains 1 (set wins).
- Hold FIFO at level 3, deassert ucpden -> next cycle fifo_lvl=0, rxne=0, flags=0, rxpaysz retained. Then ic_rst pulse mid-push -> all outputs 0 asynchronously.
